// File: rtl/sram_responder_if.sv
// Handshake side of the external SRAM bus: direction, word address and completion.
// The tristate data bus stays a plain inout port on the responder.
`timescale 1ns/1ps
interface sram_responder_if #(
   parameter int ADDR_WIDTH = 18
);
   logic                  SRAMWEn;
   logic [ADDR_WIDTH-1:0] SRAMaddress;
   logic                  SRAMready;

   modport master (output SRAMWEn, output SRAMaddress, input SRAMready);
   modport slave  (input SRAMWEn, input SRAMaddress, output SRAMready);
endinterface

// File: rtl/sram_responder.sv
// Wait-state SRAM slave: internal word array behind a restart-on-change access FSM.
// Optional macro SRAM_ADDR_CHECK_EN adds addr_err and blocks out-of-range accesses.
`timescale 1ns/1ps
module sram_responder #(
   parameter int ADDR_WIDTH  = 18,
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH_LOG2  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   sram_responder_if.slave       bus,
   inout  wire  [DATA_WIDTH-1:0] SRAMdata
`ifdef SRAM_ADDR_CHECK_EN
   ,
   output logic                  addr_err
`endif
);
   // state    | meaning
   // IDLE     | after reset, no access sampled yet
   // RD_WAIT  | read wait states counting
   // RD_VALID | read data held on the bus, ready high
   // WR_WAIT  | write wait states counting
   // WR_DONE  | write committed, ready high, further bus data ignored
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_WAIT  = 3'd1,
      RD_VALID = 3'd2,
      WR_WAIT  = 3'd3,
      WR_DONE  = 3'd4
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [3:0]              r_cnt;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_rd;
   logic [DATA_WIDTH-1:0]   r_mem [0:(1<<DEPTH_LOG2)-1];

   logic                    w_is_rd;
   logic                    w_is_wr;
   logic                    w_addr_chg;
   logic                    w_restart;
   logic                    w_last;
   logic                    w_rd_fire;
   logic                    w_wr_fire;
   logic                    w_drive;
   logic                    w_oob;
   logic [DEPTH_LOG2-1:0]   w_idx;

   assign w_idx      = r_addr[DEPTH_LOG2-1:0];
   assign w_is_rd    = (r_state == RD_WAIT) || (r_state == RD_VALID);
   assign w_is_wr    = (r_state == WR_WAIT) || (r_state == WR_DONE);
   assign w_addr_chg = (bus.SRAMaddress != r_addr);
   assign w_restart  = bus.SRAMWEn ? (!w_is_rd || w_addr_chg) : (!w_is_wr || w_addr_chg);
   assign w_last     = (r_cnt == 4'(WAIT_CYCLES - 1));

`ifdef SRAM_ADDR_CHECK_EN
   assign w_oob    = |r_addr[ADDR_WIDTH-1:DEPTH_LOG2];
   assign addr_err = w_oob;
`else
   assign w_oob    = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_fire   = 1'b0;
      w_wr_fire   = 1'b0;
      if (w_restart) begin
         w_state_nxt = bus.SRAMWEn ? RD_WAIT : WR_WAIT;
      end else begin
         case (r_state)
            RD_WAIT: if (w_last) begin
               w_state_nxt = RD_VALID;
               w_rd_fire   = 1'b1;
            end
            WR_WAIT: if (w_last) begin
               w_state_nxt = WR_DONE;
               w_wr_fire   = !w_oob;
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end

   // Release happens combinationally on SRAMWEn so the initiator can drive at once.
   always_comb begin
      bus.SRAMready = (r_state == RD_VALID) || (r_state == WR_DONE);
      w_drive       = (r_state == RD_VALID) && bus.SRAMWEn;
   end

   assign SRAMdata = w_drive ? r_rd : {DATA_WIDTH{1'bz}};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt  <= 4'd0;
         r_addr <= '0;
         r_rd   <= '0;
      end else begin
         if (w_restart) begin
            r_cnt  <= 4'd0;
            r_addr <= bus.SRAMaddress;
         end else if ((r_state == RD_WAIT) || (r_state == WR_WAIT)) begin
            r_cnt <= r_cnt + 4'd1;
         end
         if (w_rd_fire) r_rd <= w_oob ? '0 : r_mem[w_idx];
      end
   end

   // Array is deliberately outside reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (w_wr_fire) r_mem[w_idx] <= SRAMdata;
   end
endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: latency, restart, hold, reset and aliasing scenarios.
`timescale 1ns/1ps
module tb_sram_responder;
   localparam int AW = 18;
   localparam int DW = 16;
   localparam int WAIT = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          tb_oe = 1'b0;
   logic [DW-1:0] tb_dout = '0;
   wire  [DW-1:0] sram_data;
`ifdef SRAM_ADDR_CHECK_EN
   logic          addr_err;
`endif

   int total = 0;
   int bad   = 0;
   logic [DW-1:0] model [1024];
   logic [DW-1:0] sb [$];

   sram_responder_if #(.ADDR_WIDTH(AW)) bus_if ();

   sram_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(10), .WAIT_CYCLES(WAIT)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus_if.slave),
      .SRAMdata (sram_data)
`ifdef SRAM_ADDR_CHECK_EN
      ,
      .addr_err (addr_err)
`endif
   );

   assign sram_data = tb_oe ? tb_dout : {DW{1'bz}};

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic oob(input logic [AW-1:0] a);
`ifdef SRAM_ADDR_CHECK_EN
      return |a[AW-1:10];
`else
      return 1'b0;
`endif
   endfunction

   task automatic wait_ready(output int n);
      n = 0;
      while (n < 20) begin
         step();
         n++;
         if (bus_if.SRAMready === 1'b1) break;
      end
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      bus_if.SRAMWEn = 1'b0;
      bus_if.SRAMaddress = a;
      tb_dout = d;
      tb_oe = 1'b1;
      wait_ready(n);
      total++;
      if (n !== WAIT + 1) begin
         bad++;
         $display("FAIL wr_latency addr=%h got=%0d exp=%0d", a, n, WAIT + 1);
      end
      if (!oob(a)) model[a[9:0]] = d;
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      int n;
      logic [DW-1:0] e;
      bus_if.SRAMWEn = 1'b1;
      bus_if.SRAMaddress = a;
      tb_oe = 1'b0;
      sb.push_back(oob(a) ? '0 : model[a[9:0]]);
      wait_ready(n);
      total++;
      if (n !== WAIT + 1) begin
         bad++;
         $display("FAIL rd_latency addr=%h got=%0d exp=%0d", a, n, WAIT + 1);
      end
      e = sb.pop_front();
      total++;
      if (sram_data !== e) begin
         bad++;
         $display("FAIL rd_data addr=%h got=%h exp=%h", a, sram_data, e);
      end
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b0;
      bus_if.SRAMWEn = 1'b1;
      bus_if.SRAMaddress = 18'h00005;
      tb_oe = 1'b0;
      repeat (3) step();
      total++;
      if (bus_if.SRAMready !== 1'b0) begin
         bad++;
         $display("FAIL reset_ready got=%b exp=0", bus_if.SRAMready);
      end
      total++;
      if (u_dut.w_drive !== 1'b0) begin
         bad++;
         $display("FAIL reset_bus_release got=%b exp=0", u_dut.w_drive);
      end
      rst = 1'b1;
      wait_ready(n);
      total++;
      if (n !== WAIT + 1) begin
         bad++;
         $display("FAIL reset_first_latency got=%0d exp=%0d", n, WAIT + 1);
      end
   endtask

   task automatic test_write_read();
      do_write(18'h00010, 16'hBEEF);
      do_read(18'h00010);
      // drop SRAMWEn mid-cycle: bus must let go before the next edge
      bus_if.SRAMWEn = 1'b0;
      #1;
      total++;
      if (u_dut.w_drive !== 1'b0) begin
         bad++;
         $display("FAIL comb_release got=%b exp=0", u_dut.w_drive);
      end
      total++;
      if (bus_if.SRAMready !== 1'b1) begin
         bad++;
         $display("FAIL ready_hold_before_edge got=%b exp=1", bus_if.SRAMready);
      end
      step();
      total++;
      if (bus_if.SRAMready !== 1'b0) begin
         bad++;
         $display("FAIL ready_fall_on_restart got=%b exp=0", bus_if.SRAMready);
      end
   endtask

   task automatic test_addr_change();
      int n;
      logic [DW-1:0] e;
      do_write(18'h00011, 16'hC0DE);
      bus_if.SRAMWEn = 1'b1;
      bus_if.SRAMaddress = 18'h00010;
      tb_oe = 1'b0;
      step();
      step();
      total++;
      if (bus_if.SRAMready !== 1'b0) begin
         bad++;
         $display("FAIL rd_wait_not_ready got=%b exp=0", bus_if.SRAMready);
      end
      bus_if.SRAMaddress = 18'h00011;
      sb.push_back(model[10'h011]);
      wait_ready(n);
      total++;
      if (n !== WAIT + 1) begin
         bad++;
         $display("FAIL restart_latency got=%0d exp=%0d", n, WAIT + 1);
      end
      e = sb.pop_front();
      total++;
      if (sram_data !== e) begin
         bad++;
         $display("FAIL restart_data got=%h exp=%h", sram_data, e);
      end
   endtask

   task automatic test_wr_done_hold();
      do_write(18'h00020, 16'h1234);
      tb_dout = 16'h5678;
      repeat (3) step();
      total++;
      if (bus_if.SRAMready !== 1'b1) begin
         bad++;
         $display("FAIL wr_done_ready_hold got=%b exp=1", bus_if.SRAMready);
      end
      do_read(18'h00020);
      do_write(18'h00020, 16'h5678);
      do_read(18'h00020);
   endtask

   task automatic test_reset_mid_write();
      do_write(18'h00030, 16'h0001);
      do_read(18'h00030);
      bus_if.SRAMWEn = 1'b0;
      bus_if.SRAMaddress = 18'h00030;
      tb_dout = 16'hAAAA;
      tb_oe = 1'b1;
      step();
      rst = 1'b0;
      bus_if.SRAMWEn = 1'b1;
      tb_oe = 1'b0;
      step();
      rst = 1'b1;
      do_read(18'h00030);
   endtask

   task automatic test_alias();
      do_write(18'h00000, 16'h1111);
      do_write(18'h00400, 16'h7777);
`ifdef SRAM_ADDR_CHECK_EN
      total++;
      if (addr_err !== 1'b1) begin
         bad++;
         $display("FAIL addr_err_high got=%b exp=1", addr_err);
      end
`endif
      do_read(18'h00000);
`ifdef SRAM_ADDR_CHECK_EN
      total++;
      if (addr_err !== 1'b0) begin
         bad++;
         $display("FAIL addr_err_low got=%b exp=0", addr_err);
      end
`endif
      do_read(18'h00400);
      do_read(18'h3F005);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         logic [AW-1:0] a;
         a = AW'(18'h00100 + i);
         do_write(a, DW'($urandom_range(0, 16'hFFFF)));
      end
      for (int i = 3; i >= 0; i--) begin
         logic [AW-1:0] a;
         a = AW'(18'h00100 + i);
         do_read(a);
      end
   endtask

   initial begin
      bus_if.SRAMWEn = 1'b1;
      bus_if.SRAMaddress = '0;
      for (int i = 0; i < 1024; i++) model[i] = '0;
      test_reset();
      test_write_read();
      test_addr_change();
      test_wr_done_hold();
      test_reset_mid_write();
      test_alias();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable, clocked slave for the processor's external SRAM bus; the memory-side end of the SRAMWEn / SRAMaddress / SRAMdata interface.
- Stores words in an internal array and applies a programmable number of wait states before each access completes.
- Signals completion on SRAMready.
- Used as the on-chip SRAM substitute and as the bus partner in processor simulation.

Parameters:
- ADDR_WIDTH, 18, width of SRAMaddress.
- DATA_WIDTH, 16, width of SRAMdata.
- DEPTH_LOG2, 10, log2 of implemented words; the array holds 2^DEPTH_LOG2 words.
- WAIT_CYCLES, 2, clock edges from address sample to access completion; legal range 1 to 15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low: 0 resets, 1 runs.
- SRAMWEn  input  1  write enable, active-low: 0 selects write, 1 selects read.
- SRAMaddress  input  ADDR_WIDTH  word address from the initiator.
- SRAMdata  inout  DATA_WIDTH  bidirectional data bus; driven by the initiator on writes, by this block on valid reads.
- SRAMready  output  1  high while the current access is complete.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, wait counter=0, read register=0, SRAMready=0, SRAMdata released to high-Z. Array contents are not cleared.
- Sampling: at every rising edge, SRAMWEn and SRAMaddress are sampled and compared with the held copy of the previous address and direction.
- States: IDLE, RD_WAIT, RD_VALID, WR_WAIT, WR_DONE.
- Restart rule, applied first in every state including IDLE:
  - SRAMWEn=1, and the current state is not RD_* or the address changed: go to RD_WAIT, counter=0, latch the address.
  - SRAMWEn=0, and the current state is not WR_* or the address changed: go to WR_WAIT, counter=0, latch the address.
- RD_WAIT: counter increments each edge. On the edge where counter==WAIT_CYCLES-1:
  - load the read register from mem[addr[DEPTH_LOG2-1:0]];
  - go to RD_VALID.
- RD_VALID: SRAMready=1; SRAMdata driven from the read register. Holds until a restart.
- WR_WAIT: counter increments each edge. On the edge where counter==WAIT_CYCLES-1:
  - write the SRAMdata value sampled at that edge to mem[addr[DEPTH_LOG2-1:0]];
  - go to WR_DONE.
- WR_DONE: SRAMready=1; no further writes occur.
  - Data changes at the same address are ignored.
  - A new write needs an address change or a SRAMWEn 1→0 transition.
- Latency: the access completes WAIT_CYCLES edges after the sampling edge. SRAMready rises after that edge and falls after the edge that detects a restart.
- Bus drive: SRAMdata is driven only in RD_VALID with SRAMWEn=1; otherwise high-Z. If SRAMWEn falls to 0, the bus is released combinationally, with no wait for the next edge.
- Upper address bits: bits at and above DEPTH_LOG2 are ignored, so addresses alias modulo 2^DEPTH_LOG2.
- Simultaneous address change and direction change: treated as a single restart in the new direction.
- Reset mid-access: the pending write is abandoned and the array is unchanged. A read in progress releases the bus immediately.

Optional Feature:
- Macro: SRAM_ADDR_CHECK_EN.
- When defined:
  - adds port addr_err (output, 1): high while the latched address is ≥ 2^DEPTH_LOG2; reset value 0;
  - out-of-range writes complete (SRAMready=1) but do not modify the array;
  - out-of-range reads return all zeros.
- When not defined: no addr_err port; addresses alias silently as described above.

Test Plan:
- Reset held low 3 cycles while SRAMWEn=1 with SRAMaddress=0x00005 → SRAMready=0, SRAMdata=Z. After rst=1, SRAMready rises 2 edges later (WAIT_CYCLES=2).
- Write 0xBEEF to address 0x00010 (SRAMWEn=0, held 3 cycles), then read 0x00010 → SRAMready after 2 edges; SRAMdata=0xBEEF.
- Address change 0x00010→0x00011 during RD_WAIT → counter restarts; SRAMready is delayed a full WAIT_CYCLES from the change; data equals mem[0x00011].
- In WR_DONE at 0x00020 holding 0x1234, change the bus to 0x5678 with the same address → a later read of 0x00020 returns 0x1234. A SRAMWEn 1→0 toggle, then reading back, returns 0x5678.
- rst pulsed low in WR_WAIT while writing 0xAAAA to 0x00030 (previously 0x0001) → read returns 0x0001.
- With SRAM_ADDR_CHECK_EN, write 0x7777 to 0x00400 → addr_err=1; a read of 0x00000 is unchanged; a read of 0x00400 returns 0x0000. Without the macro, the same write lands at 0x00000.
